sal_req_arbiter: RTL and testbench
==================================

SAL_REQ_ARBITER -- requirements
Module: sal_req_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- NUM_REQ, default 4, number of requesters (2..8).
- DATA_WIDTH, default 32, request payload width.
- DEPTH_LG2, default 2, log2 depth of each per-requester FIFO.
- MAX_BURST, default 4, maximum consecutive grants to one requester (1..15).

REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept (FIFO not full).
- req_data_i  in  NUM_REQ x DATA_WIDTH  per-requester payload.
- gnt_valid_o  out  1  granted request valid.
- gnt_ready_i  in  1  downstream accept.
- gnt_data_o  out  DATA_WIDTH  granted payload.
- gnt_id_o  out  clog2(NUM_REQ)  index of the granted requester.

Function
REQ-003 Each requester SHALL own one FIFO of 2^DEPTH_LG2 entries; req_ready_o[i] = ~full[i], registered.
REQ-004 A push to FIFO i SHALL occur only when req_valid_i[i] & req_ready_o[i]; the entry is visible (empty[i] low) on the following cycle.
REQ-005 Requester i SHALL be eligible when FIFO i is not empty.
REQ-006 The output stage SHALL load when ~gnt_valid_o | gnt_ready_i.
REQ-007 On a load with at least one eligible requester, the block SHALL pop exactly the winner's FIFO, register its head into gnt_data_o and gnt_id_o, and set gnt_valid_o to 1.
REQ-008 On a load with no eligible requester, gnt_valid_o SHALL become 0.
REQ-009 While gnt_valid_o & ~gnt_ready_i, gnt_valid_o, gnt_data_o and gnt_id_o SHALL hold stable, and no FIFO SHALL be popped.
REQ-010 Winner selection:
- If last_id is eligible and 0 < burst_cnt < MAX_BURST, the winner is last_id.
- Otherwise the winner is the first eligible index searching last_id+1, last_id+2, ... modulo NUM_REQ, ending with last_id itself.
REQ-011 On each grant, if the winner equals last_id, burst_cnt SHALL increment; otherwise burst_cnt SHALL be 1 and last_id SHALL take the winner.
REQ-012 burst_cnt SHALL be 4 bits and SHALL never exceed MAX_BURST.
REQ-013 Minimum latency SHALL be 2 cycles: a push at edge t gives gnt_valid_o at edge t+2 when the output stage is free.
REQ-014 Sustained throughput SHALL be 1 grant per cycle while gnt_ready_i=1 and any FIFO is non-empty.
REQ-015 A simultaneous push and pop on the same FIFO SHALL leave its occupancy unchanged; a push to a full FIFO and a pop from an empty FIFO SHALL never occur.
REQ-016 Per-requester order SHALL be preserved (FIFO); there is no ordering guarantee across requesters.

Reset
REQ-017 While rst_n=0 at a clock edge:
- gnt_valid_o=0, gnt_data_o=0, gnt_id_o=0.
- All FIFOs empty, so req_ready_o all 1 after the first post-reset edge.
- last_id=NUM_REQ-1, burst_cnt=0.
REQ-018 Reset asserted mid-operation SHALL discard all queued and held requests within that edge, with no partial grant afterwards.

Structure
REQ-019 The NUM_REQ, DATA_WIDTH and MAX_BURST defaults and the grant-id width function SHALL live in the shared SAL package.
REQ-020 The per-requester queue SHALL be one reused sub-module, SAL_FIFO, instantiated NUM_REQ times; arbitration and the output register SHALL be in this module.

Verification
REQ-021 Reset, then a single push on req 2 with data 0xA5 -> gnt_valid_o=1 two cycles later, gnt_id_o=2, gnt_data_o=0xA5.
REQ-022 All 4 FIFOs preloaded with 4 entries each, MAX_BURST=4, gnt_ready_i=1 -> ids 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3.
REQ-023 MAX_BURST=1, reqs 1 and 3 each holding 3 entries -> ids 1,3,1,3,1,3.
REQ-024 gnt_ready_i=0 for 5 cycles while gnt_valid_o=1 -> outputs stable, req_ready_o falls after 4 further pushes to that FIFO; grants resume unchanged on release.
REQ-025 Continuous push on req 0 at full rate with gnt_ready_i=1 -> one grant per cycle, no overflow, data in push order.
REQ-026 rst_n pulsed low for 1 cycle with 3 entries queued and gnt_valid_o=1 -> gnt_valid_o=0 next edge and no stale data ever granted.

Source files
------------

// File: rtl/sal_req_arbiter_pkg.sv
// Shared constants and helpers for the SAL request arbiter and its queues.
package sal_req_arbiter_pkg;

  localparam int SAL_NUM_REQ    = 4;
  localparam int SAL_DATA_WIDTH = 32;
  localparam int SAL_MAX_BURST  = 4;
  localparam int SAL_BURST_W    = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int sal_id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/sal_req_arbiter_fifo.sv
// Per-requester queue: registered full/empty, a pushed entry becomes poppable one cycle after it lands.
module sal_fifo
  import sal_req_arbiter_pkg::*;
#(
  parameter int WIDTH     = SAL_DATA_WIDTH,
  parameter int DEPTH_LG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int DEPTH = 1 << DEPTH_LG2;
  localparam logic [DEPTH_LG2:0]   CNT_ONE  = (DEPTH_LG2 + 1)'(1);
  localparam logic [DEPTH_LG2:0]   CNT_FULL = (DEPTH_LG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LG2-1:0] PTR_ONE  = DEPTH_LG2'(1);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH_LG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LG2:0]   count_q, count_d;
  logic                 empty_q, full_q;
  logic                 push, pop;

  assign push = push_i & ~full_q;
  assign pop  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      // The entry written on this edge stays hidden until the next one.
      empty_q <= (count_d == {{DEPTH_LG2{1'b0}}, push});
      full_q  <= (count_d == CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/sal_req_arbiter.sv
// Round-robin request arbiter with bounded bursts, per-requester queues and a registered grant stage.
module sal_req_arbiter
  import sal_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = SAL_NUM_REQ,
  parameter int DATA_WIDTH = SAL_DATA_WIDTH,
  parameter int DEPTH_LG2  = 2,
  parameter int MAX_BURST  = SAL_MAX_BURST,
  localparam int ID_W      = sal_id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic                          gnt_valid_o,
  input  logic                          gnt_ready_i,
  output logic [DATA_WIDTH-1:0]         gnt_data_o,
  output logic [ID_W-1:0]               gnt_id_o
);

  localparam logic [SAL_BURST_W-1:0] BURST_MAX = SAL_BURST_W'(MAX_BURST);
  localparam logic [SAL_BURST_W-1:0] BURST_ONE = SAL_BURST_W'(1);
  localparam logic [ID_W-1:0]        LAST_RST  = ID_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]    empty, full, pop, eligible;
  logic [DATA_WIDTH-1:0] head [NUM_REQ];
  logic                  load, any_elig, keep;
  logic [ID_W-1:0]       winner, cand;
  int                    idx;

  logic                   gnt_valid_q, gnt_valid_d;
  logic [DATA_WIDTH-1:0]  gnt_data_q, gnt_data_d;
  logic [ID_W-1:0]        gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]        last_id_q, last_id_d;
  logic [SAL_BURST_W-1:0] burst_q, burst_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    sal_fifo #(
      .WIDTH     (DATA_WIDTH),
      .DEPTH_LG2 (DEPTH_LG2)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (req_valid_i[i]),
      .data_i  (req_data_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .pop_i   (pop[i]),
      .data_o  (head[i]),
      .empty_o (empty[i]),
      .full_o  (full[i])
    );
  end

  assign req_ready_o = ~full;
  assign eligible    = ~empty;
  assign any_elig    = |eligible;
  assign load        = ~gnt_valid_q | gnt_ready_i;

  // Descending scan so the nearest index after last_id is assigned last and wins.
  always_comb begin
    keep   = eligible[last_id_q] && (burst_q != '0) && (burst_q < BURST_MAX);
    winner = last_id_q;
    idx    = 0;
    cand   = '0;
    if (!keep) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx  = (int'(last_id_q) + k) % NUM_REQ;
        cand = ID_W'(idx);
        if (eligible[cand]) winner = cand;
      end
    end
  end

  always_comb begin
    gnt_valid_d = gnt_valid_q;
    gnt_data_d  = gnt_data_q;
    gnt_id_d    = gnt_id_q;
    last_id_d   = last_id_q;
    burst_d     = burst_q;
    pop         = '0;
    if (load) begin
      gnt_valid_d = any_elig;
      if (any_elig) begin
        pop[winner] = 1'b1;
        gnt_data_d  = head[winner];
        gnt_id_d    = winner;
        if (winner == last_id_q) begin
          if (burst_q < BURST_MAX) burst_d = burst_q + BURST_ONE;
        end else begin
          burst_d   = BURST_ONE;
          last_id_d = winner;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_valid_q <= 1'b0;
      gnt_data_q  <= '0;
      gnt_id_q    <= '0;
      last_id_q   <= LAST_RST;
      burst_q     <= '0;
    end else begin
      gnt_valid_q <= gnt_valid_d;
      gnt_data_q  <= gnt_data_d;
      gnt_id_q    <= gnt_id_d;
      last_id_q   <= last_id_d;
      burst_q     <= burst_d;
    end
  end

  assign gnt_valid_o = gnt_valid_q;
  assign gnt_data_o  = gnt_data_q;
  assign gnt_id_o    = gnt_id_q;

endmodule

// File: tb/tb_sal_req_arbiter.sv
// Directed bench for sal_req_arbiter: default instance plus a MAX_BURST=1 instance.
module tb_sal_req_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]   a_vld, a_rdy;
  logic [N*W-1:0] a_data;
  logic           a_gv, a_gr;
  logic [W-1:0]   a_gd;
  logic [1:0]     a_gid;

  logic [N-1:0]   b_vld, b_rdy;
  logic [N*W-1:0] b_data;
  logic           b_gv, b_gr;
  logic [W-1:0]   b_gd;
  logic [1:0]     b_gid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sal_req_arbiter u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (a_vld),
    .req_ready_o (a_rdy),
    .req_data_i  (a_data),
    .gnt_valid_o (a_gv),
    .gnt_ready_i (a_gr),
    .gnt_data_o  (a_gd),
    .gnt_id_o    (a_gid)
  );

  sal_req_arbiter #(.MAX_BURST(1)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (b_vld),
    .req_ready_o (b_rdy),
    .req_data_i  (b_data),
    .gnt_valid_o (b_gv),
    .gnt_ready_i (b_gr),
    .gnt_data_o  (b_gd),
    .gnt_id_o    (b_gid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_vld = '0; a_data = '0; a_gr = 1'b1;
    b_vld = '0; b_data = '0; b_gr = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (a_gv !== 1'b0 || a_gd !== 32'h0 || a_gid !== 2'd0) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%h id=%0d expected v=0 d=0 id=0", a_gv, a_gd, a_gid);
    end
    checks++;
    if (a_rdy !== 4'hF || b_rdy !== 4'hF) begin
      errors++;
      $display("FAIL reset_ready: got a=%b b=%b expected 1111", a_rdy, b_rdy);
    end
  endtask

  task automatic test_single_push();
    do_reset();
    a_vld[2] = 1'b1;
    a_data[2*W +: W] = 32'hA5;
    step();
    a_vld = '0;
    checks++;
    if (a_gv !== 1'b0) begin
      errors++;
      $display("FAIL single_lat1: got v=%b expected 0", a_gv);
    end
    step();
    checks++;
    if (a_gv !== 1'b0) begin
      errors++;
      $display("FAIL single_lat2: got v=%b expected 0", a_gv);
    end
    step();
    checks++;
    if (a_gv !== 1'b1 || a_gid !== 2'd2 || a_gd !== 32'hA5) begin
      errors++;
      $display("FAIL single_grant: got v=%b id=%0d d=%h expected v=1 id=2 d=a5", a_gv, a_gid, a_gd);
    end
    step();
    checks++;
    if (a_gv !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got v=%b expected 0", a_gv);
    end
  endtask

  task automatic test_burst_rr();
    logic [1:0]  eid;
    logic [31:0] ed;
    do_reset();
    a_gr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_vld = 4'hF;
      for (int i = 0; i < N; i++) a_data[i*W +: W] = 32'(i*16 + k);
      step();
    end
    a_vld = '0;
    a_gr  = 1'b1;
    for (int j = 0; j < 16; j++) begin
      eid = 2'(j / 4);
      ed  = 32'((j / 4) * 16 + (j % 4));
      checks++;
      if (a_gv !== 1'b1 || a_gid !== eid || a_gd !== ed) begin
        errors++;
        $display("FAIL burst_rr[%0d]: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", j, a_gv, a_gid, a_gd, eid, ed);
      end
      step();
    end
    checks++;
    if (a_gv !== 1'b0) begin
      errors++;
      $display("FAIL burst_rr_end: got v=%b expected 0", a_gv);
    end
  endtask

  task automatic test_burst_one();
    logic [1:0]  eid;
    logic [31:0] ed;
    do_reset();
    b_gr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b_vld = 4'b1010;
      b_data[1*W +: W] = 32'(16'h10 + k);
      b_data[3*W +: W] = 32'(16'h30 + k);
      step();
    end
    b_vld = '0;
    b_gr  = 1'b1;
    for (int j = 0; j < 6; j++) begin
      eid = (j % 2 == 0) ? 2'd1 : 2'd3;
      ed  = 32'(((j % 2 == 0) ? 16'h10 : 16'h30) + j / 2);
      checks++;
      if (b_gv !== 1'b1 || b_gid !== eid || b_gd !== ed) begin
        errors++;
        $display("FAIL burst_one[%0d]: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", j, b_gv, b_gid, b_gd, eid, ed);
      end
      step();
    end
    checks++;
    if (b_gv !== 1'b0) begin
      errors++;
      $display("FAIL burst_one_end: got v=%b expected 0", b_gv);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ed;
    do_reset();
    a_gr = 1'b0;
    a_vld[1] = 1'b1;
    a_data[1*W +: W] = 32'h200;
    step();
    a_vld = '0;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        checks++;
        if (a_rdy[1] !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready_before[%0d]: got %b expected 1", c, a_rdy[1]);
        end
        a_vld[1] = 1'b1;
        a_data[1*W +: W] = 32'(32'h201 + c);
      end else begin
        a_vld = '0;
      end
      step();
      checks++;
      if (a_gv !== 1'b1 || a_gid !== 2'd1 || a_gd !== 32'h200) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%h expected v=1 id=1 d=200", c, a_gv, a_gid, a_gd);
      end
    end
    checks++;
    if (a_rdy[1] !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got ready=%b expected 0", a_rdy[1]);
    end
    a_gr = 1'b1;
    for (int j = 0; j < 5; j++) begin
      ed = 32'(32'h200 + j);
      checks++;
      if (a_gv !== 1'b1 || a_gid !== 2'd1 || a_gd !== ed) begin
        errors++;
        $display("FAIL bp_resume[%0d]: got v=%b id=%0d d=%h expected v=1 id=1 d=%h", j, a_gv, a_gid, a_gd, ed);
      end
      step();
    end
    checks++;
    if (a_gv !== 1'b0 || a_rdy !== 4'hF) begin
      errors++;
      $display("FAIL bp_end: got v=%b ready=%b expected v=0 ready=1111", a_gv, a_rdy);
    end
  endtask

  task automatic test_stream();
    int got = 0;
    int first = -1;
    int last = -1;
    int bad_ready = 0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (c < 12) begin
        if (a_rdy[0] !== 1'b1) bad_ready++;
        a_vld[0] = 1'b1;
        a_data[0 +: W] = 32'(32'h300 + c);
      end else begin
        a_vld = '0;
      end
      step();
      if (a_gv === 1'b1) begin
        checks++;
        if (got >= 12 || a_gid !== 2'd0 || a_gd !== 32'(32'h300 + got)) begin
          errors++;
          $display("FAIL stream_data[%0d]: got id=%0d d=%h expected id=0 d=%h", got, a_gid, a_gd, 32'h300 + got);
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    checks++;
    if (got != 12) begin
      errors++;
      $display("FAIL stream_count: got %0d grants expected 12", got);
    end
    checks++;
    if (last - first != 11) begin
      errors++;
      $display("FAIL stream_rate: got span %0d cycles expected 11", last - first);
    end
    checks++;
    if (bad_ready != 0) begin
      errors++;
      $display("FAIL stream_ready: got %0d cycles not ready expected 0", bad_ready);
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    do_reset();
    a_gr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_vld[3] = 1'b1;
      a_data[3*W +: W] = 32'(32'h400 + k);
      step();
    end
    a_vld = '0;
    checks++;
    if (a_gv !== 1'b1 || a_gd !== 32'h400) begin
      errors++;
      $display("FAIL rmid_pre: got v=%b d=%h expected v=1 d=400", a_gv, a_gd);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (a_gv !== 1'b0 || a_rdy !== 4'hF) begin
      errors++;
      $display("FAIL rmid_cleared: got v=%b ready=%b expected v=0 ready=1111", a_gv, a_rdy);
    end
    a_gr = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (a_gv !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL rmid_stale: got %0d stale grant cycles expected 0", stale);
    end
    a_vld[0] = 1'b1;
    a_data[0 +: W] = 32'h500;
    step();
    a_vld = '0;
    step();
    step();
    checks++;
    if (a_gv !== 1'b1 || a_gid !== 2'd0 || a_gd !== 32'h500) begin
      errors++;
      $display("FAIL rmid_restart: got v=%b id=%0d d=%h expected v=1 id=0 d=500", a_gv, a_gid, a_gd);
    end
  endtask

  initial begin
    a_vld = '0; a_data = '0; a_gr = 1'b1;
    b_vld = '0; b_data = '0; b_gr = 1'b1;
    test_reset();
    test_single_push();
    test_burst_rr();
    test_burst_one();
    test_backpressure();
    test_stream();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
